fetch_pc_predictor: RTL and testbench
=====================================

Name: fetch_pc_predictor

Overview:
Fetch-stage next-PC generator that consumes the branch target buffer's lookup result. It holds the architectural fetch PC and drives the BTB read index. It also keeps a per-entry valid bit and a 2-bit bimodal direction table, and selects the predicted next PC. Branch resolution from EX updates the tables, drives the BTB write port and redirects fetch on a mispredict.

Parameters:
ADDRESS_WIDTH, 22, width of the word-addressed PC and of branch targets
BUFFER_SIZE, 8, index width; the BTB and both local tables have 2**BUFFER_SIZE entries
RESET_PC, 0, PC value loaded on reset

Ports:
i_Clk  input  1  clock; all state updates on rising edge
i_Reset  input  1  asynchronous, active-high reset
i_Stall  input  1  hold the PC (decode/hazard stall)
o_pc  output  ADDRESS_WIDTH  current fetch PC
o_btb_index  output  BUFFER_SIZE  BTB read index, equal to o_pc[BUFFER_SIZE-1:0]
i_btb_target  input  ADDRESS_WIDTH  BTB read data for o_btb_index (combinational)
o_pred_taken  output  1  prediction for o_pc, piped to EX by the pipeline
o_pred_target  output  ADDRESS_WIDTH  predicted target for o_pc
i_ex_valid  input  1  EX holds a valid instruction
i_ex_is_branch  input  1  EX instruction is a branch or jump
i_ex_pc  input  ADDRESS_WIDTH  PC of the EX instruction
i_ex_taken  input  1  resolved direction
i_ex_target  input  ADDRESS_WIDTH  resolved target
i_ex_pred_taken  input  1  o_pred_taken carried with the EX instruction
i_ex_pred_target  input  ADDRESS_WIDTH  o_pred_target carried with the EX instruction
o_flush  output  1  squash IF/ID this cycle; redirect takes effect next edge
o_btb_wr_en  output  1  BTB write enable
o_btb_wr_index  output  BUFFER_SIZE  equal to i_ex_pc[BUFFER_SIZE-1:0]
o_btb_wr_target  output  ADDRESS_WIDTH  equal to i_ex_target

Behaviour:
- Reset (asynchronous): PC=RESET_PC; all counters=WNT (01); all valid bits=0.
- While i_Reset is high, o_flush, o_btb_wr_en and o_pred_taken are forced to 0.
- Lookup (combinational, index idx=o_pc[BUFFER_SIZE-1:0]): o_pred_taken = valid[idx] & counter[idx][1].
- o_pred_target = i_btb_target when o_pred_taken is 1, otherwise o_pc+1.
- Resolution: res = i_ex_valid & i_ex_is_branch.
- Mispredict, branch case: res & ((i_ex_taken != i_ex_pred_taken) | (i_ex_taken & i_ex_pred_target != i_ex_target)).
- Mispredict, aliasing case: i_ex_valid & !i_ex_is_branch & i_ex_pred_taken (false BTB hit).
- o_flush = mispredict, combinational.
- Redirect PC = i_ex_target if (res & i_ex_taken), otherwise i_ex_pc+1.
- Next-PC priority, loaded at the edge:
  1. mispredict -> redirect PC
  2. i_Stall -> hold
  3. otherwise -> o_pred_target
- A mispredict overrides a concurrent stall.
- Counter update when res, at eidx=i_ex_pc[BUFFER_SIZE-1:0]:
  - taken: saturating increment, 11 stays 11
  - not taken: saturating decrement, 00 stays 00
- When res & i_ex_taken: o_btb_wr_en=1 and valid[eidx] is set at the edge.
- Aliasing mispredict: valid[eidx] is cleared at the edge; the counter is unchanged; o_btb_wr_en=0.
- Updates to idx during the same cycle as a lookup of idx: the lookup sees the pre-edge values. There is no bypass.
- Arithmetic: PC+1 wraps modulo 2**ADDRESS_WIDTH, so all-ones+1 = 0.
- The stall does not block table updates; EX resolution is independent of fetch stall.
- Reset asserted mid-operation: state returns to reset values immediately; any pending redirect is discarded.

Decomposition:
- Shared package (bp_pkg) holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - CTR_RESET=WNT
  - the saturating next-state function
- One sub-module, sat_counter_table:
  - parameter BUFFER_SIZE
  - async reset
  - one combinational read port
  - one update port (en, index, taken)
- The valid-bit array and the PC register stay in the top level.

Test Plan:
- Reset, then 4 cycles with no EX activity -> o_pc sequence 0,1,2,3; o_pred_taken=0; o_flush=0.
- EX resolves a branch at pc 0x10, taken, target 0x40, pred_taken=0 -> o_flush=1 that cycle; o_btb_wr_en=1 with wr_index 0x10; next o_pc=0x40; counter[0x10]=WT; valid[0x10]=1.
- With that entry trained and the BTB returning 0x40, fetch at 0x10 -> o_pred_taken=1, next o_pc=0x40. Resolve not-taken twice -> first resolve: counter 10->01 and flush to 0x11; second resolve: counter 01->00 and flush to 0x11.
- Non-branch at EX with i_ex_pred_taken=1, i_ex_pc=0x22 -> o_flush=1, next o_pc=0x23, valid[0x22] cleared, o_btb_wr_en=0.
- i_Stall=1 concurrent with a mispredict to 0x80 -> next o_pc=0x80. Then i_Stall=1 alone for 3 cycles -> o_pc holds 0x80.
- o_pc=0x3FFFFF, no prediction -> next o_pc=0x000000. Assert i_Reset between clock edges -> o_pc=RESET_PC immediately; o_flush=0.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the fetch-stage branch predictor: the 2-bit bimodal
// counter encoding, its reset value and the saturating next-state function.
// ---------------------------------------------------------------------------
package bp_pkg;

    // Bimodal direction counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    // Saturating step toward the resolved direction.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = ctr_t'(2'(cur) + 2'd1);
            end
        end else begin
            if (cur != SNT) begin
                nxt = ctr_t'(2'(cur) - 2'd1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// ---------------------------------------------------------------------------
// sat_counter_table
// Table of 2**BUFFER_SIZE saturating 2-bit direction counters.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (all -> WNT)
//   rd_index, rd_ctr   combinational read port (sees pre-edge contents)
//   upd_en, upd_index,
//   upd_taken          one saturating update per cycle toward upd_taken
// ---------------------------------------------------------------------------
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUFFER_SIZE-1:0] rd_index,
    output ctr_t                   rd_ctr,
    input  logic                   upd_en,
    input  logic [BUFFER_SIZE-1:0] upd_index,
    input  logic                   upd_taken
);

    localparam int unsigned DEPTH = 2 ** BUFFER_SIZE;

    ctr_t ctr_q [DEPTH];

    // Counter storage; no read bypass, so a same-cycle update is seen next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            ctr_q[upd_index] <= ctr_next(ctr_q[upd_index], upd_taken);
        end
    end

    assign rd_ctr = ctr_q[rd_index];

endmodule

// File: rtl/fetch_pc_predictor.sv
// ---------------------------------------------------------------------------
// fetch_pc_predictor
// Fetch-stage next-PC generator. Holds the fetch PC, indexes the external BTB,
// combines the BTB target with a per-entry valid bit and a bimodal direction
// counter to predict the next PC, and applies EX branch resolution (table
// training, BTB write, redirect on mispredict).
// Ports:
//   i_Clk, i_Reset          clock, asynchronous active-high reset
//   i_Stall                 hold the fetch PC
//   o_pc, o_btb_index       fetch PC and BTB read index (PC low bits)
//   i_btb_target            BTB read data for o_btb_index
//   o_pred_taken,
//   o_pred_target           prediction for o_pc
//   i_ex_*                  resolved instruction from EX with its prediction
//   o_flush                 mispredict: squash IF/ID, redirect at next edge
//   o_btb_wr_en/_index/_target  BTB write port (taken branches)
// ---------------------------------------------------------------------------
module fetch_pc_predictor
    import bp_pkg::*;
#(
    parameter int unsigned               ADDRESS_WIDTH = 22,
    parameter int unsigned               BUFFER_SIZE   = 8,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic [BUFFER_SIZE-1:0]   o_btb_index,
    input  logic [ADDRESS_WIDTH-1:0] i_btb_target,
    output logic                     o_pred_taken,
    output logic [ADDRESS_WIDTH-1:0] o_pred_target,
    input  logic                     i_ex_valid,
    input  logic                     i_ex_is_branch,
    input  logic [ADDRESS_WIDTH-1:0] i_ex_pc,
    input  logic                     i_ex_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_ex_target,
    input  logic                     i_ex_pred_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_ex_pred_target,
    output logic                     o_flush,
    output logic                     o_btb_wr_en,
    output logic [BUFFER_SIZE-1:0]   o_btb_wr_index,
    output logic [ADDRESS_WIDTH-1:0] o_btb_wr_target
);

    localparam int unsigned              DEPTH  = 2 ** BUFFER_SIZE;
    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic [DEPTH-1:0]         valid_q;
    logic [BUFFER_SIZE-1:0]   idx;
    logic [BUFFER_SIZE-1:0]   eidx;
    ctr_t                     ctr_rd;
    logic                     hit;
    logic                     res;
    logic                     res_taken;
    logic                     mis_branch;
    logic                     mis_alias;
    logic                     mispredict;

    assign idx  = pc_q[BUFFER_SIZE-1:0];
    assign eidx = i_ex_pc[BUFFER_SIZE-1:0];

    // Direction counters; trained by every resolved branch.
    sat_counter_table #(
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_ctr_table (
        .clk       (i_Clk),
        .rst       (i_Reset),
        .rd_index  (idx),
        .rd_ctr    (ctr_rd),
        .upd_en    (res),
        .upd_index (eidx),
        .upd_taken (i_ex_taken)
    );

    // Lookup and resolution decode.
    always_comb begin
        hit         = 1'b0;
        res         = 1'b0;
        res_taken   = 1'b0;
        mis_branch  = 1'b0;
        mis_alias   = 1'b0;
        mispredict  = 1'b0;
        redirect_pc = i_ex_pc + PC_ONE;

        hit       = valid_q[idx] & ((ctr_rd == WT) | (ctr_rd == ST));
        res       = i_ex_valid & i_ex_is_branch;
        res_taken = res & i_ex_taken;

        // Wrong direction, or taken with a stale predicted target.
        mis_branch = res & ((i_ex_taken != i_ex_pred_taken) |
                            (i_ex_taken & (i_ex_pred_target != i_ex_target)));
        // A non-branch was predicted taken: the BTB entry belongs to another PC.
        mis_alias  = i_ex_valid & ~i_ex_is_branch & i_ex_pred_taken;
        mispredict = mis_branch | mis_alias;

        if (res_taken) begin
            redirect_pc = i_ex_target;
        end
    end

    // Outputs; reset masks the control strobes.
    always_comb begin
        o_pc            = pc_q;
        o_btb_index     = idx;
        o_pred_taken    = hit & ~i_Reset;
        o_pred_target   = pc_q + PC_ONE;
        o_flush         = mispredict & ~i_Reset;
        o_btb_wr_en     = res_taken & ~i_Reset;
        o_btb_wr_index  = eidx;
        o_btb_wr_target = i_ex_target;

        if (o_pred_taken) begin
            o_pred_target = i_btb_target;
        end
    end

    // Next-PC select: mispredict beats stall beats prediction.
    always_comb begin
        pc_d = o_pred_target;
        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (i_Stall) begin
            pc_d = pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB valid bits: set on taken resolution, cleared on an aliasing hit.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            valid_q <= '0;
        end else if (res_taken) begin
            valid_q[eidx] <= 1'b1;
        end else if (mis_alias) begin
            valid_q[eidx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
module tb_fetch_pc_predictor;

    localparam int AW    = 22;
    localparam int BS    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [AW-1:0] pc;
    logic [BS-1:0] btb_index;
    logic [AW-1:0] btb_target;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          ex_valid;
    logic          ex_is_branch;
    logic [AW-1:0] ex_pc;
    logic          ex_taken;
    logic [AW-1:0] ex_target;
    logic          ex_pred_taken;
    logic [AW-1:0] ex_pred_target;
    logic          flush;
    logic          wr_en;
    logic [BS-1:0] wr_index;
    logic [AW-1:0] wr_target;

    int checks = 0;
    int errors = 0;

    fetch_pc_predictor #(
        .ADDRESS_WIDTH (AW),
        .BUFFER_SIZE   (BS),
        .RESET_PC      (22'h0)
    ) dut (
        .i_Clk            (clk),
        .i_Reset          (rst),
        .i_Stall          (stall),
        .o_pc             (pc),
        .o_btb_index      (btb_index),
        .i_btb_target     (btb_target),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_ex_valid       (ex_valid),
        .i_ex_is_branch   (ex_is_branch),
        .i_ex_pc          (ex_pc),
        .i_ex_taken       (ex_taken),
        .i_ex_target      (ex_target),
        .i_ex_pred_taken  (ex_pred_taken),
        .i_ex_pred_target (ex_pred_target),
        .o_flush          (flush),
        .o_btb_wr_en      (wr_en),
        .o_btb_wr_index   (wr_index),
        .o_btb_wr_target  (wr_target)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall          = 1'b0;
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_pc          = '0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
        btb_target     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_ex(input logic br, input logic [AW-1:0] epc, input logic tk,
                          input logic [AW-1:0] tgt, input logic ptk, input logic [AW-1:0] ptg);
        ex_valid       = 1'b1;
        ex_is_branch   = br;
        ex_pc          = epc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptg;
    endtask

    // Redirect fetch via a taken mispredict from a PC whose index is never fetched.
    task automatic goto(input logic [AW-1:0] tgt);
        set_ex(1'b1, 22'h1F0, 1'b1, tgt, 1'b0, 22'h0);
        settle();
        tick();
        idle();
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_ex(1'b1, 22'h10, 1'b1, 22'h40, 1'b0, 22'h0);
        #3;
        checks++; if (pc !== 22'h0)     begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 22'h0); end
        checks++; if (flush !== 1'b0)   begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
        checks++; if (wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
        tick();
        rst = 1'b0;
        idle();
        settle();
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc !== AW'(i)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, AW'(i)); end
            checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL seq_pred got %b exp 0", pred_taken); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush got %b exp 0", flush); end
            tick();
            settle();
        end
    endtask

    task automatic test_train_taken();
        set_ex(1'b1, 22'h10, 1'b1, 22'h40, 1'b0, 22'h11);
        settle();
        checks++; if (flush !== 1'b1)     begin errors++; $display("FAIL train_flush got %b exp 1", flush); end
        checks++; if (wr_en !== 1'b1)     begin errors++; $display("FAIL train_wr_en got %b exp 1", wr_en); end
        checks++; if (wr_index !== 8'h10) begin errors++; $display("FAIL train_wr_index got %h exp 10", wr_index); end
        checks++; if (wr_target !== 22'h40) begin errors++; $display("FAIL train_wr_target got %h exp 40", wr_target); end
        tick();
        idle();
        settle();
        checks++; if (pc !== 22'h40) begin errors++; $display("FAIL train_next_pc got %h exp 40", pc); end
    endtask

    task automatic test_predict_untrain();
        goto(22'h10);
        btb_target = 22'h40;
        settle();
        checks++; if (pc !== 22'h10) begin errors++; $display("FAIL goto_pc got %h exp 10", pc); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL hit_pred got %b exp 1", pred_taken); end
        checks++; if (pred_target !== 22'h40) begin errors++; $display("FAIL hit_target got %h exp 40", pred_target); end
        tick();
        settle();
        checks++; if (pc !== 22'h40) begin errors++; $display("FAIL hit_next_pc got %h exp 40", pc); end
        for (int k = 0; k < 2; k++) begin
            set_ex(1'b1, 22'h10, 1'b0, 22'h40, 1'b1, 22'h40);
            settle();
            checks++; if (flush !== 1'b1) begin errors++; $display("FAIL nt_flush%0d got %b exp 1", k, flush); end
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL nt_wr_en%0d got %b exp 0", k, wr_en); end
            tick();
            idle();
            settle();
            checks++; if (pc !== 22'h11) begin errors++; $display("FAIL nt_pc%0d got %h exp 11", k, pc); end
        end
        goto(22'h10);
        btb_target = 22'h40;
        settle();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL untrained_pred got %b exp 0", pred_taken); end
        checks++; if (pred_target !== 22'h11) begin errors++; $display("FAIL untrained_target got %h exp 11", pred_target); end
    endtask

    task automatic test_alias();
        set_ex(1'b1, 22'h22, 1'b1, 22'h30, 1'b0, 22'h0);
        settle();
        tick();
        idle();
        goto(22'h22);
        btb_target = 22'h30;
        settle();
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_pre_pred got %b exp 1", pred_taken); end
        set_ex(1'b0, 22'h22, 1'b0, 22'h0, 1'b1, 22'h30);
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL alias_flush got %b exp 1", flush); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL alias_wr_en got %b exp 0", wr_en); end
        tick();
        idle();
        settle();
        checks++; if (pc !== 22'h23) begin errors++; $display("FAIL alias_pc got %h exp 23", pc); end
        goto(22'h22);
        btb_target = 22'h30;
        settle();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_cleared got %b exp 0", pred_taken); end
        checks++; if (pred_target !== 22'h23) begin errors++; $display("FAIL alias_target got %h exp 23", pred_target); end
    endtask

    task automatic test_stall_mispredict();
        stall = 1'b1;
        set_ex(1'b1, 22'h50, 1'b1, 22'h80, 1'b0, 22'h0);
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_mis_flush got %b exp 1", flush); end
        tick();
        idle();
        stall = 1'b1;
        settle();
        checks++; if (pc !== 22'h80) begin errors++; $display("FAIL stall_mis_pc got %h exp 80", pc); end
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            checks++; if (pc !== 22'h80) begin errors++; $display("FAIL stall_hold%0d got %h exp 80", k, pc); end
        end
        stall = 1'b0;
        tick();
        settle();
        checks++; if (pc !== 22'h81) begin errors++; $display("FAIL stall_release got %h exp 81", pc); end
    endtask

    task automatic test_wrap();
        goto(22'h3FFFFF);
        checks++; if (pred_target !== 22'h0) begin errors++; $display("FAIL wrap_target got %h exp 0", pred_target); end
        tick();
        settle();
        checks++; if (pc !== 22'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        set_ex(1'b1, 22'h60, 1'b1, 22'h123, 1'b0, 22'h0);
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pre_reset_flush got %b exp 1", flush); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 22'h0)   begin errors++; $display("FAIL async_pc got %h exp 0", pc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL async_flush got %b exp 0", flush); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL async_wr_en got %b exp 0", wr_en); end
        tick();
        rst = 1'b0;
        idle();
        settle();
        checks++; if (pc !== 22'h0) begin errors++; $display("FAIL post_reset_pc got %h exp 0", pc); end
        goto(22'h10);
        btb_target = 22'h40;
        settle();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL post_reset_table got %b exp 0", pred_taken); end
    endtask

    // Randomised run against a table-level model of the predictor.
    task automatic test_random();
        logic [AW-1:0] pc_m;
        bit            valid_m [DEPTH];
        int            ctr_m   [DEPTH];
        logic [AW-1:0] btb_m   [DEPTH];
        int            idx_m;
        int            eidx_m;
        bit            e_pt;
        logic [AW-1:0] e_ptg;
        bit            e_res;
        bit            e_alias;
        bit            e_mis;
        bit            e_wr;
        logic [AW-1:0] e_next;

        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        settle();
        pc_m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_m[i] = 1'b0;
            ctr_m[i]   = 1;
            btb_m[i]   = '0;
        end

        for (int cyc = 0; cyc < 1500; cyc++) begin
            idx_m          = int'(pc_m[BS-1:0]);
            stall          = ($urandom_range(0, 3) == 0);
            ex_valid       = ($urandom_range(0, 9) < 7);
            ex_is_branch   = ($urandom_range(0, 4) != 0);
            ex_pc          = pc_m - AW'($urandom_range(0, 3));
            ex_taken       = 1'($urandom_range(0, 1));
            ex_target      = ($urandom_range(0, 15) == 0) ? 22'h3FFFFC + AW'($urandom_range(0, 3))
                                                          : AW'($urandom_range(0, 47));
            ex_pred_taken  = 1'($urandom_range(0, 1));
            ex_pred_target = ($urandom_range(0, 9) < 7) ? ex_target : AW'($urandom_range(0, 47));
            btb_target     = btb_m[idx_m];
            settle();

            eidx_m  = int'(ex_pc[BS-1:0]);
            e_pt    = valid_m[idx_m] && (ctr_m[idx_m] >= 2);
            e_ptg   = e_pt ? btb_m[idx_m] : pc_m + 22'd1;
            e_res   = ex_valid && ex_is_branch;
            e_alias = ex_valid && !ex_is_branch && ex_pred_taken;
            e_mis   = (e_res && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)))) || e_alias;
            e_wr    = e_res && ex_taken;
            if (e_mis)      e_next = (e_res && ex_taken) ? ex_target : ex_pc + 22'd1;
            else if (stall) e_next = pc_m;
            else            e_next = e_ptg;

            checks++; if (pc !== pc_m) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, pc, pc_m); end
            checks++; if (btb_index !== pc_m[BS-1:0]) begin errors++; $display("FAIL rnd_index cyc %0d got %h exp %h", cyc, btb_index, pc_m[BS-1:0]); end
            checks++; if (pred_taken !== e_pt) begin errors++; $display("FAIL rnd_pred cyc %0d got %b exp %b", cyc, pred_taken, e_pt); end
            checks++; if (pred_target !== e_ptg) begin errors++; $display("FAIL rnd_target cyc %0d got %h exp %h", cyc, pred_target, e_ptg); end
            checks++; if (flush !== e_mis) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", cyc, flush, e_mis); end
            checks++; if (wr_en !== e_wr) begin errors++; $display("FAIL rnd_wr_en cyc %0d got %b exp %b", cyc, wr_en, e_wr); end
            if (e_wr) begin
                checks++; if (wr_index !== ex_pc[BS-1:0]) begin errors++; $display("FAIL rnd_wr_index cyc %0d got %h exp %h", cyc, wr_index, ex_pc[BS-1:0]); end
                checks++; if (wr_target !== ex_target) begin errors++; $display("FAIL rnd_wr_target cyc %0d got %h exp %h", cyc, wr_target, ex_target); end
            end

            if (e_res) begin
                if (ex_taken) ctr_m[eidx_m] = (ctr_m[eidx_m] == 3) ? 3 : ctr_m[eidx_m] + 1;
                else          ctr_m[eidx_m] = (ctr_m[eidx_m] == 0) ? 0 : ctr_m[eidx_m] - 1;
            end
            if (e_wr) begin
                valid_m[eidx_m] = 1'b1;
                btb_m[eidx_m]   = ex_target;
            end else if (e_alias) begin
                valid_m[eidx_m] = 1'b0;
            end
            pc_m = e_next;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_predict_untrain();
        test_alias();
        test_stall_mispredict();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
